// File: rtl/acker_timer_bank_pkg.sv
// Shared definitions for the timer bank: default sizes, channel state encoding
// and the channel-index width helper.
package acker_timer_bank_pkg;

   localparam int DEF_TIMER_WIDTH    = 26;
   localparam int DEF_NUM_CH         = 4;
   localparam int DEF_PRESCALE_WIDTH = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_t;

   // A single-channel bank still carries a 1-bit index so out-of-range values exist.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/acker_timer_channel.sv
// One down-counting timer channel: counter, reload value, mode bit and the
// registered done/expire flags. Advances only on the shared prescaler tick.
module acker_timer_channel
   import acker_timer_bank_pkg::*;
#(
   parameter int TIMER_WIDTH = DEF_TIMER_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   tick,
   input  logic                   ld,
   input  logic [TIMER_WIDTH-1:0] ld_val,
   input  logic                   ld_per,
   input  logic                   stop,
   output logic                   done,
   output logic                   expire
);

   ch_state_t              state;
   logic [TIMER_WIDTH-1:0] count;
   logic [TIMER_WIDTH-1:0] reload;
   logic                   periodic;

   // Priority is load, then stop, then tick; a load or stop in the expiry
   // cycle therefore swallows that expire pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         count    <= '0;
         reload   <= '0;
         periodic <= 1'b0;
         done     <= 1'b1;
         expire   <= 1'b0;
      end else begin
         expire <= 1'b0;
         if (ld) begin
            count    <= ld_val;
            reload   <= ld_val;
            periodic <= ld_per;
            if (ld_val != '0) begin
               state <= ST_RUN;
               done  <= 1'b0;
            end else begin
               state <= ST_IDLE;
               done  <= 1'b1;
            end
         end else if (stop) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b1;
         end else if (state == ST_RUN && tick) begin
            if (count == TIMER_WIDTH'(1)) begin
               expire <= 1'b1;
               if (periodic) begin
                  count <= reload;
               end else begin
                  state <= ST_IDLE;
                  count <= '0;
                  done  <= 1'b1;
               end
            end else begin
               count <= count - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/acker_timer_bank.sv
// Bank of independent down-counting timers sharing one programmable prescaler.
// Handshake: load_en/stop_en are single-cycle strobes, no ready; acted on at the next edge.
module acker_timer_bank
   import acker_timer_bank_pkg::*;
#(
   parameter int TIMER_WIDTH    = DEF_TIMER_WIDTH,
   parameter int NUM_CH         = DEF_NUM_CH,
   parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [PRESCALE_WIDTH-1:0]     prescale,
   input  logic                          load_en,
   input  logic [ch_idx_w(NUM_CH)-1:0]   load_ch,
   input  logic [TIMER_WIDTH-1:0]        load_val,
   input  logic                          load_periodic,
   input  logic                          stop_en,
   input  logic [ch_idx_w(NUM_CH)-1:0]   stop_ch,
   output logic [NUM_CH-1:0]             done,
   output logic [NUM_CH-1:0]             expire,
   output logic                          busy
);

   localparam int CH_IDX_W = ch_idx_w(NUM_CH);

   logic [PRESCALE_WIDTH-1:0] pre_cnt;
   logic                      tick;

   // Using >= lets a prescale value lowered below the current count wrap at once.
   assign tick = (pre_cnt >= prescale);

   always_ff @(posedge clock) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ld;
      logic st;

      assign ld = load_en && (load_ch == CH_IDX_W'(i));
      assign st = stop_en && (stop_ch == CH_IDX_W'(i));

      acker_timer_channel #(
         .TIMER_WIDTH (TIMER_WIDTH)
      ) u_ch (
         .clock  (clock),
         .reset  (reset),
         .tick   (tick),
         .ld     (ld),
         .ld_val (load_val),
         .ld_per (load_periodic),
         .stop   (st),
         .done   (done[i]),
         .expire (expire[i])
      );
   end

   assign busy = ~&done;

endmodule

// File: tb/tb_acker_timer_bank.sv
// Self-checking bench for acker_timer_bank: deadline-based reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_acker_timer_bank;
   import acker_timer_bank_pkg::*;

   localparam int NCH = 6;
   localparam int TW  = 26;
   localparam int PW  = 8;
   localparam int IW  = ch_idx_w(NCH);

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [PW-1:0]   prescale = '0;
   logic            load_en = 1'b0;
   logic [IW-1:0]   load_ch = '0;
   logic [TW-1:0]   load_val = '0;
   logic            load_periodic = 1'b0;
   logic            stop_en = 1'b0;
   logic [IW-1:0]   stop_ch = '0;
   logic [NCH-1:0]  done;
   logic [NCH-1:0]  expire;
   logic            busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic [31:0] exp_q[$];

   acker_timer_bank #(
      .TIMER_WIDTH    (TW),
      .NUM_CH         (NCH),
      .PRESCALE_WIDTH (PW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .prescale      (prescale),
      .load_en       (load_en),
      .load_ch       (load_ch),
      .load_val      (load_val),
      .load_periodic (load_periodic),
      .stop_en       (stop_en),
      .stop_ch       (stop_ch),
      .done          (done),
      .expire        (expire),
      .busy          (busy)
   );

   // ---------------- clock / reset block ----------------
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // Each running channel holds the absolute prescaler-tick number at which it
   // is due; it expires in the cycle whose tick reaches that number.
   int unsigned m_pc;
   longint      m_tnum;
   bit          m_act [NCH];
   longint      m_due [NCH];
   longint      m_len [NCH];
   bit          m_per [NCH];
   logic [NCH-1:0] m_done;
   logic [NCH-1:0] m_exp;
   bit          m_valid = 1'b0;

   always @(posedge clock) begin : model
      bit     tk;
      longint t;
      if (reset) begin
         m_pc    <= 0;
         m_tnum  <= 0;
         m_done  <= '1;
         m_exp   <= '0;
         m_valid <= 1'b1;
         for (int c = 0; c < NCH; c++) m_act[c] <= 1'b0;
      end else begin
         tk = (m_pc >= prescale);
         t  = m_tnum + (tk ? 1 : 0);
         m_tnum <= t;
         m_pc   <= tk ? 0 : m_pc + 1;
         for (int c = 0; c < NCH; c++) begin
            m_exp[c] <= 1'b0;
            if (load_en && int'(load_ch) == c) begin
               if (load_val != 0) begin
                  m_act[c]  <= 1'b1;
                  m_due[c]  <= t + longint'(load_val);
                  m_len[c]  <= longint'(load_val);
                  m_per[c]  <= load_periodic;
                  m_done[c] <= 1'b0;
               end else begin
                  m_act[c]  <= 1'b0;
                  m_done[c] <= 1'b1;
               end
            end else if (stop_en && int'(stop_ch) == c) begin
               m_act[c]  <= 1'b0;
               m_done[c] <= 1'b1;
            end else if (m_act[c] && tk && t == m_due[c]) begin
               m_exp[c] <= 1'b1;
               if (m_per[c]) begin
                  m_due[c] <= m_due[c] + m_len[c];
               end else begin
                  m_act[c]  <= 1'b0;
                  m_done[c] <= 1'b1;
               end
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (m_valid) begin
         compare("model_done",   32'(done),   32'(m_done));
         compare("model_expire", 32'(expire), 32'(m_exp));
         compare("model_busy",   32'(busy),   32'(~&m_done));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input int ch, input int n, input bit per);
      load_en       = 1'b1;
      load_ch       = IW'(ch);
      load_val      = TW'(n);
      load_periodic = per;
      cycle();
      load_en = 1'b0;
   endtask

   task automatic stop(input int ch);
      stop_en = 1'b1;
      stop_ch = IW'(ch);
      cycle();
      stop_en = 1'b0;
   endtask

   task automatic wait_expire(input int ch, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         cycle();
         if (expire[ch]) begin
            at = cyc;
            break;
         end
      end
      n_cmp++;
      if (at < 0) begin
         n_bad++;
         $display("FAIL wait_expire ch%0d: none within %0d cycles, required one", ch, budget);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c0, c1, c, cnt;

      repeat (3) cycle();
      reset = 1'b0;
      compare("rst_done",   32'(done),   32'({NCH{1'b1}}));
      compare("rst_expire", 32'(expire), 32'h0);
      compare("rst_busy",   32'(busy),   32'h0);

      // 1: P=0 one-shot N=5 on ch0
      load(0, 5, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         compare("t1_done0_low", 32'(done[0]), 32'h0);
         cycle();
      end
      compare("t1_done0_low_e4", 32'(done[0]), 32'h0);
      cycle();
      compare("t1_expire0_e5", 32'(expire[0]), 32'h1);
      compare("t1_done0_e5",   32'(done[0]),   32'h1);
      cycle();
      compare("t1_expire0_e6", 32'(expire[0]), 32'h0);

      // 2: P=3 periodic N=3 on ch1
      prescale = 8'd3;
      cycle();
      load(1, 3, 1'b1);
      c0 = cyc;
      wait_expire(1, 20, c1);
      compare("t2_first_latency_in_range", 32'((c1 - c0 >= 9) && (c1 - c0 <= 12)), 32'h1);
      for (int k = 1; k <= 4; k++) exp_q.push_back(32'(c1 + 12 * k));
      while (exp_q.size() > 0) begin
         wait_expire(1, 20, c);
         compare("t2_period_stamp", 32'(c), exp_q.pop_front());
         compare("t2_done1_low",    32'(done[1]), 32'h0);
      end
      stop(1);
      compare("t2_done1_after_stop", 32'(done[1]), 32'h1);
      cnt = 0;
      repeat (30) begin
         cycle();
         if (expire[1]) cnt++;
      end
      compare("t2_no_expire_after_stop", 32'(cnt), 32'h0);

      // 3: P=0, ch2 N=4 reloaded three clocks later
      prescale = 8'd0;
      cycle();
      load(2, 4, 1'b0);
      cycle();
      cycle();
      load(2, 4, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         cycle();
         compare("t3_no_early_expire", 32'(expire[2]), 32'h0);
      end
      cycle();
      compare("t3_expire_after_reload", 32'(expire[2]), 32'h1);
      cycle();
      compare("t3_single_expire", 32'(expire[2]), 32'h0);

      // 4: load beats stop on ch3; ch0 loaded while ch1 expires
      load_en = 1'b1; load_ch = IW'(3); load_val = TW'(6); load_periodic = 1'b0;
      stop_en = 1'b1; stop_ch = IW'(3);
      cycle();
      load_en = 1'b0; stop_en = 1'b0;
      compare("t4_ch3_running", 32'(done[3]), 32'h0);
      compare("t4_busy",        32'(busy),    32'h1);
      load(1, 3, 1'b0);
      cycle();
      cycle();
      load(0, 1, 1'b0);
      compare("t4_expire1",      32'(expire[1]), 32'h1);
      compare("t4_done0_loaded", 32'(done[0]),   32'h0);
      cycle();
      compare("t4_expire0_next", 32'(expire[0]), 32'h1);
      compare("t4_expire1_gone", 32'(expire[1]), 32'h0);

      // 5: N=0 load, out-of-range load, reset at counter 1
      for (int k = 0; k < NCH; k++) stop(k);
      load(2, 0, 1'b0);
      compare("t5_n0_done", 32'(done), 32'({NCH{1'b1}}));
      cnt = 0;
      repeat (5) begin
         cycle();
         if (expire != '0) cnt++;
      end
      compare("t5_n0_no_expire", 32'(cnt), 32'h0);
      load(NCH, 5, 1'b0);
      compare("t5_oor_done", 32'(done), 32'({NCH{1'b1}}));
      compare("t5_oor_busy", 32'(busy), 32'h0);
      load(0, 3, 1'b0);
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      compare("t5_rst_no_expire", 32'(expire), 32'h0);
      compare("t5_rst_done",      32'(done),   32'({NCH{1'b1}}));

      // 6: prescale 200 -> 2 while prescaler count is 100
      reset = 1'b1;
      prescale = 8'd200;
      cycle();
      reset = 1'b0;
      repeat (49) cycle();
      load(0, 1, 1'b1);
      repeat (50) cycle();
      prescale = 8'd2;
      cycle();
      compare("t6_tick_after_shrink", 32'(expire[0]), 32'h1);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         compare("t6_tick_every_3", 32'(expire[0]), 32'((k % 3) == 0));
      end

      // random phase, checked by the compare process against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 3));
         load_en       = ($urandom_range(0, 9) == 0);
         load_ch       = IW'($urandom_range(0, 7));
         load_val      = TW'($urandom_range(0, 12));
         load_periodic = ($urandom_range(0, 1) == 1);
         stop_en       = ($urandom_range(0, 14) == 0);
         stop_ch       = IW'($urandom_range(0, 7));
         reset         = ($urandom_range(0, 399) == 0);
         cycle();
      end
      load_en = 1'b0;
      stop_en = 1'b0;
      reset   = 1'b0;
      repeat (5) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/acker_timer_bank.md
Name: acker_timer_bank

Overview:
- Bank of NUM_CH independent down-counting timers sharing one programmable prescaler.
- Each channel runs in one-shot or periodic (auto-reload) mode. Each channel can be loaded, restarted or stopped at any time.
- Provides a level "done" and a one-cycle "expire" pulse per channel.
- Serves as the central wait and tick source for control FSMs, such as motor sequencing and sensor polling periods.

Parameters:
- TIMER_WIDTH, 26, width of each channel counter and of load_val.
- NUM_CH, 4, number of timer channels; legal range 1..16.
- PRESCALE_WIDTH, 8, width of the prescaler divider value.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- prescale  in  PRESCALE_WIDTH  divider value P; one tick every P+1 clocks.
- load_en  in  1  load strobe for channel load_ch.
- load_ch  in  CH_IDX_W  channel addressed by load_en.
- load_val  in  TIMER_WIDTH  start/reload value N in ticks.
- load_periodic  in  1  mode latched on load: 1 = periodic, 0 = one-shot.
- stop_en  in  1  stop strobe for channel stop_ch.
- stop_ch  in  CH_IDX_W  channel addressed by stop_en.
- done  out  NUM_CH  1 = channel idle (counter zero); registered.
- expire  out  NUM_CH  one-clock pulse per channel expiry; registered.
- busy  out  1  OR of all channels running.

Behaviour:
- Reset:
  - All counters, reload registers and mode bits go to 0 and all channels to IDLE.
  - Prescaler count goes to 0.
  - done = all ones, expire = 0, busy = 0.
- Prescaler:
  - Free-running count 0..P.
  - tick=1 in the cycle where count==P, and count then wraps to 0.
  - P=0 gives tick every cycle.
  - If prescale changes so that count > P, the next cycle wraps to 0 with tick=1.
  - The prescaler is cleared only by reset, never by load.
- Per-channel states: IDLE (counter==0) and RUN (counter!=0).
- Load (load_en, load_ch=c) with N != 0:
  - counter <= N, reload <= N, periodic <= load_periodic, and the channel enters RUN.
  - done[c] drops on the next edge.
  - Loading a running channel restarts it; there is no expire for the aborted run.
- Load with N == 0:
  - Channel goes to IDLE with counter 0.
  - done stays or goes 1; no expire.
- RUN, tick, counter > 1: counter decrements by 1.
- RUN, tick, counter == 1:
  - One-shot: counter <= 0, go to IDLE; done[c] and expire[c] rise on the same edge.
  - Periodic: counter <= reload, stay in RUN; expire[c] pulses and done[c] stays 0.
  - Expiry period is exactly N ticks = N*(P+1) clocks.
- First-expiry latency after load:
  - Lies between (N-1)*(P+1)+1 and N*(P+1) clocks, depending on prescaler phase.
  - With P=0 it is exactly N clocks: load sampled at edge E0, expire high after edge EN.
- Stop (stop_en, stop_ch=c):
  - counter <= 0, go to IDLE, done[c] <= 1, no expire.
  - Stopping an IDLE channel has no effect.
- Simultaneous events on the same channel in the same cycle:
  - Load beats stop, and both beat tick.
  - A channel loaded or stopped in its expiry cycle produces no expire pulse.
- Different channels are fully independent: load and stop may target different channels in the same cycle.
- Out-of-range load_ch/stop_ch (>= NUM_CH) is ignored.
- No arithmetic wrap: a counter never decrements below 0, and reload is never modified except by load.
- reset asserted mid-run overrides everything on that edge. No expire pulse is produced in that cycle or after.
- busy is combinational from the registered channel states: ~&done.

Decomposition:
- Shared package/header holds:
  - CH_IDX_W = max(1, clog2(NUM_CH)).
  - State encodings ST_IDLE/ST_RUN.
  - Default parameter values.
- Sub-module acker_timer_channel:
  - One counter, reload register, mode bit, done/expire registers.
  - Inputs: tick, ld, ld_val, ld_per, stop.
- The top level instantiates NUM_CH channels in a generate loop and decodes load_ch/stop_ch into per-channel strobes.
- The prescaler lives in the top level.

Test Plan:
1. Reset then P=0, load ch0 N=5 one-shot:
   - done[0] low for 5 clocks.
   - expire[0] and done[0] high after edge 5; expire[0] low after edge 6.
2. P=3, load ch1 N=3 periodic:
   - expire[1] pulses every 12 clocks.
   - done[1] stays 0 for 4 periods.
   - After stop_ch=1, done[1]=1 with no further expire.
3. P=0, ch2 N=4 one-shot; reload ch2 with N=4 at clock 3:
   - No expire at clock 4.
   - Single expire 4 clocks after the reload.
4. Same-cycle load_en+stop_en on ch3 → ch3 runs with the loaded value.
   - Load ch0 N=1 while ch1 expires in the same cycle → both behave independently, expire[1] pulses.
5. Load N=0 → no expire and done stays 1.
   - load_ch=NUM_CH → no state change.
   - reset asserted with ch0 at counter=1 → no expire, done all ones.
6. Prescale reduced from 200 to 2 while the prescaler count is 100:
   - tick next cycle.
   - Subsequent ticks every 3 clocks.
